axi_master_arb: RTL and testbench
=================================

AXI_MASTER_ARB -- requirements
Module: axi_master_arb

Interface
REQ-001 Parameter ADDR_W, 64, address width of all address ports.
REQ-002 Parameter DATA_W, 64, AXI data width; STRB width is DATA_W/8.
REQ-003 Parameter ID_W, 4, AXI ID width; ID 4'b0000 = data, 4'b0001 = instruction.
REQ-004 clk  in  1  single block clock; all logic is posedge clk.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 if_req / if_addr  in  1 / ADDR_W  instruction-fetch request, level-held until if_done.
REQ-007 if_done / if_data  out  1 / 32  one-cycle completion pulse, with fetched word.
REQ-008 mem_rd_req / mem_wr_req  in  1 / 1  data read / write request, level-held until mem_done.
REQ-009 mem_addr / mem_wdata / mem_wstrb  in  ADDR_W / DATA_W / DATA_W/8  data request payload.
REQ-010 mem_done / mem_rdata / mem_err  out  1 / DATA_W / 1  completion pulse, read data, nonzero-response flag.
REQ-011 m_axi_aw_{id,addr,len,size,burst,valid}  out;  m_axi_aw_ready  in  write address channel.
REQ-012 m_axi_w_{data,strb,last,valid}  out;  m_axi_w_ready  in  write data channel.
REQ-013 m_axi_b_{id,resp,valid}  in;  m_axi_b_ready  out  write response channel.
REQ-014 m_axi_ar_{id,addr,len,size,burst,valid}  out;  m_axi_ar_ready  in  read address channel.
REQ-015 m_axi_r_{id,data,resp,last,valid}  in;  m_axi_r_ready  out  read data channel.

Function
REQ-016 The block SHALL hold at most one outstanding AXI transaction.
REQ-017 FSM states SHALL be IDLE, AR, R, AW, B, DONE.
REQ-018 In IDLE, fixed priority SHALL be mem_wr_req > mem_rd_req > if_req; the winner and its address, data and strobe are latched on the IDLE exit edge.
REQ-019 IDLE->AW on a write grant; IDLE->AR on a read grant; otherwise the FSM stays in IDLE.
REQ-020 Every burst SHALL be single-beat: len=0, size=3'b011, burst=2'b01, w_last=1.
REQ-021 In AW, aw_valid and w_valid SHALL assert in the same cycle; each deasserts only after its own handshake; AW->B once both handshakes are complete (same or different cycles).
REQ-022 In B, b_ready=1; B->DONE on the b handshake; mem_err latches (b_resp!=0).
REQ-023 In AR, ar_valid=1 with ar_id set by the granted source; AR->R on the ar handshake.
REQ-024 In R, r_ready=1; R->DONE on the r handshake; data and (r_resp!=0) are latched.
REQ-025 In DONE, exactly one of if_done/mem_done SHALL pulse for one cycle; DONE->IDLE unconditionally.
REQ-026 if_data SHALL be r_data[31:0] of the fetch; mem_rdata SHALL be the full r_data; both hold until the next completion.
REQ-027 Valids SHALL NOT depend combinationally on readies; payload is stable while valid is high.
REQ-028 A request that drops before its done SHALL NOT abort the transaction in flight.
REQ-029 Minimum latency with ready-high slave: read = 4 cycles from request to done pulse; write = 4 cycles.
REQ-030 Unused outputs (ids/addr/data outside their active state) SHALL drive zero.

Reset
REQ-031 On rst low: FSM=IDLE; all valids, readies, if_done, mem_done, mem_err = 0; if_data, mem_rdata, latched payload = 0.
REQ-032 Reset asserted mid-transaction SHALL immediately drop all valids; no done pulse is produced for the aborted transfer.

Structure
REQ-033 State encodings, ID constants (DATA=0, INST=1), LEN/SIZE/BURST constants and bus-width macros SHALL live in the shared defines file.
REQ-034 One sub-module, axi_arb_prio (combinational fixed-priority grant), is natural; everything else stays in one module.

Verification
REQ-035 if_req, if_addr=0x8000_0000, slave r_data=0x0000_0000_0000_0013 -> ar_id=1, ar_addr=0x8000_0000, if_done pulse, if_data=0x13.
REQ-036 mem_wr_req, addr=0x8000_1000, wdata=0xDEAD_BEEF_0123_4567, strb=0xFF -> aw/w valid same cycle, b handshake, mem_done pulse, mem_err=0.
REQ-037 if_req and mem_rd_req together -> data read (ar_id=0) served first, then fetch (ar_id=1); two done pulses in that order.
REQ-038 aw_ready delayed 3 cycles after w_ready -> w_valid drops after its handshake, aw_valid holds; a single B is accepted.
REQ-039 r_resp=2'b10 on a data read -> mem_err=1 with mem_done.
REQ-040 rst low while in R -> all valids/readies 0 next edge; no done pulse; first post-reset request completes normally.

Source files
------------

// File: rtl/axi_master_arb_pkg.sv
// Shared definitions for the AXI master arbiter: FSM states, grant codes, AXI IDs,
// single-beat burst constants and default bus widths.
package axi_master_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 64;
   localparam int unsigned DEF_DATA_W = 64;
   localparam int unsigned DEF_ID_W   = 4;
   localparam int unsigned IF_DATA_W  = 32;

   localparam int unsigned ID_DATA = 0;
   localparam int unsigned ID_INST = 1;

   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW   = 3'd3,
      ST_B    = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WR   = 2'd1,
      GNT_RD   = 2'd2,
      GNT_IF   = 2'd3
   } grant_t;

endpackage

// File: rtl/axi_arb_prio.sv
// Combinational fixed-priority grant: data write beats data read beats instruction fetch.
module axi_arb_prio
   import axi_master_arb_pkg::*;
(
   input  logic   wr_req,
   input  logic   rd_req,
   input  logic   fetch_req,
   output grant_t grant
);

   always_comb begin
      grant = GNT_NONE;
      if (wr_req)
         grant = GNT_WR;
      else if (rd_req)
         grant = GNT_RD;
      else if (fetch_req)
         grant = GNT_IF;
   end

endmodule

// File: rtl/axi_master_arb.sv
// Single-outstanding AXI4 master shared by the instruction-fetch and data ports;
// every transfer is one 64-bit beat and completes with a one-cycle done pulse.
module axi_master_arb
   import axi_master_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ID_W   = DEF_ID_W
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_done,
   output logic [IF_DATA_W-1:0]  if_data,

   input  logic                  mem_rd_req,
   input  logic                  mem_wr_req,
   input  logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W/8-1:0]   mem_wstrb,
   output logic                  mem_done,
   output logic [DATA_W-1:0]     mem_rdata,
   output logic                  mem_err,

   output logic [ID_W-1:0]       m_axi_aw_id,
   output logic [ADDR_W-1:0]     m_axi_aw_addr,
   output logic [7:0]            m_axi_aw_len,
   output logic [2:0]            m_axi_aw_size,
   output logic [1:0]            m_axi_aw_burst,
   output logic                  m_axi_aw_valid,
   input  logic                  m_axi_aw_ready,

   output logic [DATA_W-1:0]     m_axi_w_data,
   output logic [DATA_W/8-1:0]   m_axi_w_strb,
   output logic                  m_axi_w_last,
   output logic                  m_axi_w_valid,
   input  logic                  m_axi_w_ready,

   input  logic [ID_W-1:0]       m_axi_b_id,
   input  logic [1:0]            m_axi_b_resp,
   input  logic                  m_axi_b_valid,
   output logic                  m_axi_b_ready,

   output logic [ID_W-1:0]       m_axi_ar_id,
   output logic [ADDR_W-1:0]     m_axi_ar_addr,
   output logic [7:0]            m_axi_ar_len,
   output logic [2:0]            m_axi_ar_size,
   output logic [1:0]            m_axi_ar_burst,
   output logic                  m_axi_ar_valid,
   input  logic                  m_axi_ar_ready,

   input  logic [ID_W-1:0]       m_axi_r_id,
   input  logic [DATA_W-1:0]     m_axi_r_data,
   input  logic [1:0]            m_axi_r_resp,
   input  logic                  m_axi_r_last,
   input  logic                  m_axi_r_valid,
   output logic                  m_axi_r_ready
);

   state_t                state_q;
   state_t                state_d;
   grant_t                grant;

   logic                  is_fetch_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic [IF_DATA_W-1:0]  if_data_q;
   logic [DATA_W-1:0]     mem_rdata_q;
   logic                  mem_err_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  ar_hs;
   logic                  r_hs;

   // Only one transfer is ever outstanding, so response IDs and r_last carry no information.
   logic                  unused_resp_fields;
   assign unused_resp_fields = ^{m_axi_b_id, m_axi_r_id, m_axi_r_last};

   axi_arb_prio u_prio (
      .wr_req    (mem_wr_req),
      .rd_req    (mem_rd_req),
      .fetch_req (if_req),
      .grant     (grant)
   );

   assign aw_hs = m_axi_aw_valid && m_axi_aw_ready;
   assign w_hs  = m_axi_w_valid  && m_axi_w_ready;
   assign b_hs  = m_axi_b_valid  && m_axi_b_ready;
   assign ar_hs = m_axi_ar_valid && m_axi_ar_ready;
   assign r_hs  = m_axi_r_valid  && m_axi_r_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // AW leaves only once both address and data handshakes have happened, in either order.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant == GNT_WR)
               state_d = ST_AW;
            else if (grant != GNT_NONE)
               state_d = ST_AR;
         end
         ST_AW: begin
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
               state_d = ST_B;
         end
         ST_B: begin
            if (b_hs)
               state_d = ST_DONE;
         end
         ST_AR: begin
            if (ar_hs)
               state_d = ST_R;
         end
         ST_R: begin
            if (r_hs)
               state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_fetch_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && grant != GNT_NONE) begin
            is_fetch_q <= (grant == GNT_IF);
            addr_q     <= (grant == GNT_IF) ? if_addr : mem_addr;
            wdata_q    <= mem_wdata;
            wstrb_q    <= mem_wstrb;
         end
         if (state_q == ST_AW) begin
            if (aw_hs)
               aw_done_q <= 1'b1;
            if (w_hs)
               w_done_q <= 1'b1;
         end else begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if (state_q == ST_B && b_hs)
            mem_err_q <= (m_axi_b_resp != AXI_RESP_OKAY);
         if (state_q == ST_R && r_hs) begin
            if (is_fetch_q)
               if_data_q <= m_axi_r_data[IF_DATA_W-1:0];
            else begin
               mem_rdata_q <= m_axi_r_data;
               mem_err_q   <= (m_axi_r_resp != AXI_RESP_OKAY);
            end
         end
      end
   end

   // Valids come from state and handshake-done flags only; payloads are zero whenever idle.
   assign m_axi_aw_valid = (state_q == ST_AW) && !aw_done_q;
   assign m_axi_aw_id    = m_axi_aw_valid ? ID_W'(ID_DATA) : '0;
   assign m_axi_aw_addr  = m_axi_aw_valid ? addr_q : '0;
   assign m_axi_aw_len   = m_axi_aw_valid ? AXI_LEN_SINGLE : '0;
   assign m_axi_aw_size  = m_axi_aw_valid ? AXI_SIZE_8B : '0;
   assign m_axi_aw_burst = m_axi_aw_valid ? AXI_BURST_INCR : '0;

   assign m_axi_w_valid  = (state_q == ST_AW) && !w_done_q;
   assign m_axi_w_data   = m_axi_w_valid ? wdata_q : '0;
   assign m_axi_w_strb   = m_axi_w_valid ? wstrb_q : '0;
   assign m_axi_w_last   = m_axi_w_valid;

   assign m_axi_b_ready  = (state_q == ST_B);

   assign m_axi_ar_valid = (state_q == ST_AR);
   assign m_axi_ar_id    = m_axi_ar_valid ? (is_fetch_q ? ID_W'(ID_INST) : ID_W'(ID_DATA)) : '0;
   assign m_axi_ar_addr  = m_axi_ar_valid ? addr_q : '0;
   assign m_axi_ar_len   = m_axi_ar_valid ? AXI_LEN_SINGLE : '0;
   assign m_axi_ar_size  = m_axi_ar_valid ? AXI_SIZE_8B : '0;
   assign m_axi_ar_burst = m_axi_ar_valid ? AXI_BURST_INCR : '0;

   assign m_axi_r_ready  = (state_q == ST_R);

   assign if_done   = (state_q == ST_DONE) && is_fetch_q;
   assign mem_done  = (state_q == ST_DONE) && !is_fetch_q;
   assign if_data   = if_data_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_axi_master_arb.sv
// Directed bench for axi_master_arb: the bench plays the AXI slave cycle by cycle
// and checks every output against hand-computed values.
module tb_axi_master_arb;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int ID_W   = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                if_req = 1'b0;
   logic [ADDR_W-1:0]   if_addr = '0;
   logic                if_done;
   logic [31:0]         if_data;
   logic                mem_rd_req = 1'b0;
   logic                mem_wr_req = 1'b0;
   logic [ADDR_W-1:0]   mem_addr = '0;
   logic [DATA_W-1:0]   mem_wdata = '0;
   logic [DATA_W/8-1:0] mem_wstrb = '0;
   logic                mem_done;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_err;
   logic [ID_W-1:0]     m_axi_aw_id;
   logic [ADDR_W-1:0]   m_axi_aw_addr;
   logic [7:0]          m_axi_aw_len;
   logic [2:0]          m_axi_aw_size;
   logic [1:0]          m_axi_aw_burst;
   logic                m_axi_aw_valid;
   logic                m_axi_aw_ready = 1'b1;
   logic [DATA_W-1:0]   m_axi_w_data;
   logic [DATA_W/8-1:0] m_axi_w_strb;
   logic                m_axi_w_last;
   logic                m_axi_w_valid;
   logic                m_axi_w_ready = 1'b1;
   logic [ID_W-1:0]     m_axi_b_id = '0;
   logic [1:0]          m_axi_b_resp = '0;
   logic                m_axi_b_valid = 1'b0;
   logic                m_axi_b_ready;
   logic [ID_W-1:0]     m_axi_ar_id;
   logic [ADDR_W-1:0]   m_axi_ar_addr;
   logic [7:0]          m_axi_ar_len;
   logic [2:0]          m_axi_ar_size;
   logic [1:0]          m_axi_ar_burst;
   logic                m_axi_ar_valid;
   logic                m_axi_ar_ready = 1'b1;
   logic [ID_W-1:0]     m_axi_r_id = '0;
   logic [DATA_W-1:0]   m_axi_r_data = '0;
   logic [1:0]          m_axi_r_resp = '0;
   logic                m_axi_r_last = 1'b0;
   logic                m_axi_r_valid = 1'b0;
   logic                m_axi_r_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_done(mem_done),
      .mem_rdata(mem_rdata), .mem_err(mem_err),
      .m_axi_aw_id(m_axi_aw_id), .m_axi_aw_addr(m_axi_aw_addr), .m_axi_aw_len(m_axi_aw_len),
      .m_axi_aw_size(m_axi_aw_size), .m_axi_aw_burst(m_axi_aw_burst),
      .m_axi_aw_valid(m_axi_aw_valid), .m_axi_aw_ready(m_axi_aw_ready),
      .m_axi_w_data(m_axi_w_data), .m_axi_w_strb(m_axi_w_strb), .m_axi_w_last(m_axi_w_last),
      .m_axi_w_valid(m_axi_w_valid), .m_axi_w_ready(m_axi_w_ready),
      .m_axi_b_id(m_axi_b_id), .m_axi_b_resp(m_axi_b_resp), .m_axi_b_valid(m_axi_b_valid),
      .m_axi_b_ready(m_axi_b_ready),
      .m_axi_ar_id(m_axi_ar_id), .m_axi_ar_addr(m_axi_ar_addr), .m_axi_ar_len(m_axi_ar_len),
      .m_axi_ar_size(m_axi_ar_size), .m_axi_ar_burst(m_axi_ar_burst),
      .m_axi_ar_valid(m_axi_ar_valid), .m_axi_ar_ready(m_axi_ar_ready),
      .m_axi_r_id(m_axi_r_id), .m_axi_r_data(m_axi_r_data), .m_axi_r_resp(m_axi_r_resp),
      .m_axi_r_last(m_axi_r_last), .m_axi_r_valid(m_axi_r_valid), .m_axi_r_ready(m_axi_r_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready} !== 5'b0) begin failures++; $display("[TB] FAIL reset_handshake: got %b expected %b", {m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready}, 5'b0); end
      checks++; if ({if_done, mem_done, mem_err} !== 3'b0) begin failures++; $display("[TB] FAIL reset_done_err: got %b expected %b", {if_done, mem_done, mem_err}, 3'b0); end
      checks++; if (if_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_if_data: got %h expected %h", if_data, 32'h0); end
      checks++; if (mem_rdata !== 64'h0) begin failures++; $display("[TB] FAIL reset_mem_rdata: got %h expected %h", mem_rdata, 64'h0); end
      rst = 1'b1;
      tick();
      checks++; if ({m_axi_aw_valid, m_axi_ar_valid, m_axi_ar_addr, m_axi_aw_addr} !== '0) begin failures++; $display("[TB] FAIL idle_outputs: aw_valid %b ar_valid %b ar_addr %h aw_addr %h expected all zero", m_axi_aw_valid, m_axi_ar_valid, m_axi_ar_addr, m_axi_aw_addr); end
   endtask

   task automatic test_fetch();
      if_req = 1'b1;
      if_addr = 64'h0000_0000_8000_0000;
      tick();
      checks++; if ({m_axi_ar_valid, m_axi_ar_id} !== {1'b1, 4'd1}) begin failures++; $display("[TB] FAIL fetch_ar: got valid %b id %h expected valid 1 id 1", m_axi_ar_valid, m_axi_ar_id); end
      checks++; if (m_axi_ar_addr !== 64'h0000_0000_8000_0000) begin failures++; $display("[TB] FAIL fetch_ar_addr: got %h expected %h", m_axi_ar_addr, 64'h8000_0000); end
      checks++; if ({m_axi_ar_len, m_axi_ar_size, m_axi_ar_burst} !== {8'd0, 3'b011, 2'b01}) begin failures++; $display("[TB] FAIL fetch_ar_burst: got len %h size %b burst %b expected 0 011 01", m_axi_ar_len, m_axi_ar_size, m_axi_ar_burst); end
      tick();
      checks++; if ({m_axi_ar_valid, m_axi_r_ready} !== 2'b01) begin failures++; $display("[TB] FAIL fetch_r_phase: got ar_valid/r_ready %b expected %b", {m_axi_ar_valid, m_axi_r_ready}, 2'b01); end
      m_axi_r_valid = 1'b1;
      m_axi_r_data = 64'h0000_0000_0000_0013;
      m_axi_r_resp = 2'b00;
      m_axi_r_last = 1'b1;
      tick();
      checks++; if ({if_done, mem_done, m_axi_r_ready} !== 3'b100) begin failures++; $display("[TB] FAIL fetch_done: got if_done/mem_done/r_ready %b expected %b", {if_done, mem_done, m_axi_r_ready}, 3'b100); end
      checks++; if (if_data !== 32'h13) begin failures++; $display("[TB] FAIL fetch_if_data: got %h expected %h", if_data, 32'h13); end
      if_req = 1'b0;
      m_axi_r_valid = 1'b0;
      tick();
      checks++; if ({if_done, if_data} !== {1'b0, 32'h13}) begin failures++; $display("[TB] FAIL fetch_hold: got if_done %b if_data %h expected 0 13", if_done, if_data); end
   endtask

   task automatic test_write();
      mem_wr_req = 1'b1;
      mem_addr = 64'h0000_0000_8000_1000;
      mem_wdata = 64'hDEAD_BEEF_0123_4567;
      mem_wstrb = 8'hFF;
      tick();
      checks++; if ({m_axi_aw_valid, m_axi_w_valid, m_axi_w_last} !== 3'b111) begin failures++; $display("[TB] FAIL write_valids: got aw/w/last %b expected %b", {m_axi_aw_valid, m_axi_w_valid, m_axi_w_last}, 3'b111); end
      checks++; if ({m_axi_aw_addr, m_axi_aw_id} !== {64'h8000_1000, 4'd0}) begin failures++; $display("[TB] FAIL write_aw: got addr %h id %h expected 80001000 0", m_axi_aw_addr, m_axi_aw_id); end
      checks++; if ({m_axi_w_data, m_axi_w_strb} !== {64'hDEAD_BEEF_0123_4567, 8'hFF}) begin failures++; $display("[TB] FAIL write_w: got data %h strb %h expected deadbeef01234567 ff", m_axi_w_data, m_axi_w_strb); end
      checks++; if ({m_axi_aw_len, m_axi_aw_size, m_axi_aw_burst} !== {8'd0, 3'b011, 2'b01}) begin failures++; $display("[TB] FAIL write_aw_burst: got len %h size %b burst %b expected 0 011 01", m_axi_aw_len, m_axi_aw_size, m_axi_aw_burst); end
      tick();
      checks++; if ({m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready} !== 3'b001) begin failures++; $display("[TB] FAIL write_b_phase: got aw/w/b_ready %b expected %b", {m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready}, 3'b001); end
      m_axi_b_valid = 1'b1;
      m_axi_b_resp = 2'b00;
      tick();
      checks++; if ({mem_done, if_done, mem_err} !== 3'b100) begin failures++; $display("[TB] FAIL write_done: got mem_done/if_done/mem_err %b expected %b", {mem_done, if_done, mem_err}, 3'b100); end
      mem_wr_req = 1'b0;
      m_axi_b_valid = 1'b0;
      tick();
      checks++; if ({mem_done, m_axi_b_ready} !== 2'b00) begin failures++; $display("[TB] FAIL write_idle: got mem_done/b_ready %b expected %b", {mem_done, m_axi_b_ready}, 2'b00); end
   endtask

   task automatic test_priority();
      mem_rd_req = 1'b1;
      mem_addr = 64'h100;
      if_req = 1'b1;
      if_addr = 64'h200;
      tick();
      checks++; if ({m_axi_ar_id, m_axi_ar_addr} !== {4'd0, 64'h100}) begin failures++; $display("[TB] FAIL prio_first_ar: got id %h addr %h expected 0 100", m_axi_ar_id, m_axi_ar_addr); end
      tick();
      m_axi_r_valid = 1'b1;
      m_axi_r_data = 64'hA5A5_0000_1111_2222;
      m_axi_r_resp = 2'b00;
      tick();
      checks++; if ({mem_done, if_done, mem_rdata} !== {2'b10, 64'hA5A5_0000_1111_2222}) begin failures++; $display("[TB] FAIL prio_first_done: got mem_done %b if_done %b rdata %h expected 1 0 a5a5000011112222", mem_done, if_done, mem_rdata); end
      mem_rd_req = 1'b0;
      m_axi_r_valid = 1'b0;
      tick();
      checks++; if ({mem_done, if_done} !== 2'b00) begin failures++; $display("[TB] FAIL prio_gap: got mem_done/if_done %b expected %b", {mem_done, if_done}, 2'b00); end
      tick();
      checks++; if ({m_axi_ar_valid, m_axi_ar_id, m_axi_ar_addr} !== {1'b1, 4'd1, 64'h200}) begin failures++; $display("[TB] FAIL prio_second_ar: got valid %b id %h addr %h expected 1 1 200", m_axi_ar_valid, m_axi_ar_id, m_axi_ar_addr); end
      tick();
      m_axi_r_valid = 1'b1;
      m_axi_r_data = 64'h1122_3344_5566_7788;
      tick();
      checks++; if ({if_done, mem_done, if_data} !== {2'b10, 32'h5566_7788}) begin failures++; $display("[TB] FAIL prio_second_done: got if_done %b mem_done %b if_data %h expected 1 0 55667788", if_done, mem_done, if_data); end
      checks++; if (mem_rdata !== 64'hA5A5_0000_1111_2222) begin failures++; $display("[TB] FAIL prio_rdata_hold: got %h expected %h", mem_rdata, 64'hA5A5_0000_1111_2222); end
      if_req = 1'b0;
      m_axi_r_valid = 1'b0;
      tick();
   endtask

   task automatic test_aw_delay();
      m_axi_aw_ready = 1'b0;
      m_axi_w_ready = 1'b1;
      mem_wr_req = 1'b1;
      mem_rd_req = 1'b1;
      mem_addr = 64'h40;
      mem_wdata = 64'h0102_0304_0506_0708;
      mem_wstrb = 8'h0F;
      tick();
      checks++; if ({m_axi_aw_valid, m_axi_w_valid, m_axi_ar_valid} !== 3'b110) begin failures++; $display("[TB] FAIL awdly_start: got aw/w/ar valid %b expected %b", {m_axi_aw_valid, m_axi_w_valid, m_axi_ar_valid}, 3'b110); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({m_axi_aw_valid, m_axi_w_valid, m_axi_aw_addr} !== {2'b10, 64'h40}) begin failures++; $display("[TB] FAIL awdly_wait%0d: got aw %b w %b addr %h expected 1 0 40", i, m_axi_aw_valid, m_axi_w_valid, m_axi_aw_addr); end
      end
      m_axi_aw_ready = 1'b1;
      tick();
      checks++; if ({m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready} !== 3'b001) begin failures++; $display("[TB] FAIL awdly_b_phase: got aw/w/b_ready %b expected %b", {m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready}, 3'b001); end
      m_axi_b_valid = 1'b1;
      m_axi_b_resp = 2'b00;
      tick();
      checks++; if ({mem_done, m_axi_b_ready} !== 2'b10) begin failures++; $display("[TB] FAIL awdly_done: got mem_done/b_ready %b expected %b", {mem_done, m_axi_b_ready}, 2'b10); end
      m_axi_b_valid = 1'b0;
      mem_wr_req = 1'b0;
      mem_rd_req = 1'b0;
      tick();
      checks++; if ({mem_done, m_axi_b_ready, m_axi_aw_valid, m_axi_w_valid} !== 4'b0) begin failures++; $display("[TB] FAIL awdly_idle: got %b expected %b", {mem_done, m_axi_b_ready, m_axi_aw_valid, m_axi_w_valid}, 4'b0); end
   endtask

   task automatic test_read_err();
      mem_rd_req = 1'b1;
      mem_addr = 64'h80;
      tick();
      tick();
      m_axi_r_valid = 1'b1;
      m_axi_r_data = 64'h77;
      m_axi_r_resp = 2'b10;
      tick();
      checks++; if ({mem_done, mem_err, mem_rdata} !== {2'b11, 64'h77}) begin failures++; $display("[TB] FAIL rderr_done: got mem_done %b mem_err %b rdata %h expected 1 1 77", mem_done, mem_err, mem_rdata); end
      mem_rd_req = 1'b0;
      m_axi_r_valid = 1'b0;
      m_axi_r_resp = 2'b00;
      tick();
      checks++; if ({mem_done, mem_err} !== 2'b01) begin failures++; $display("[TB] FAIL rderr_hold: got mem_done/mem_err %b expected %b", {mem_done, mem_err}, 2'b01); end
   endtask

   task automatic test_reset_mid();
      mem_rd_req = 1'b1;
      mem_addr = 64'h300;
      tick();
      tick();
      checks++; if (m_axi_r_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_in_r: got r_ready %b expected 1", m_axi_r_ready); end
      rst = 1'b0;
      #1;
      checks++; if ({m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready} !== 5'b0) begin failures++; $display("[TB] FAIL rstmid_drop: got %b expected %b", {m_axi_aw_valid, m_axi_w_valid, m_axi_b_ready, m_axi_ar_valid, m_axi_r_ready}, 5'b0); end
      mem_rd_req = 1'b0;
      tick();
      checks++; if ({mem_done, if_done, mem_err, mem_rdata} !== {3'b000, 64'h0}) begin failures++; $display("[TB] FAIL rstmid_no_done: got mem_done %b if_done %b mem_err %b rdata %h expected 0 0 0 0", mem_done, if_done, mem_err, mem_rdata); end
      rst = 1'b1;
      tick();
      if_req = 1'b1;
      if_addr = 64'h8000_0040;
      tick();
      checks++; if ({m_axi_ar_valid, m_axi_ar_id, m_axi_ar_addr} !== {1'b1, 4'd1, 64'h8000_0040}) begin failures++; $display("[TB] FAIL rstmid_post_ar: got valid %b id %h addr %h expected 1 1 80000040", m_axi_ar_valid, m_axi_ar_id, m_axi_ar_addr); end
      tick();
      m_axi_r_valid = 1'b1;
      m_axi_r_data = 64'hAB;
      tick();
      checks++; if ({if_done, if_data} !== {1'b1, 32'hAB}) begin failures++; $display("[TB] FAIL rstmid_post_done: got if_done %b if_data %h expected 1 ab", if_done, if_data); end
      if_req = 1'b0;
      m_axi_r_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_write();
      test_priority();
      test_aw_delay();
      test_read_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
